// File: rtl/fdiv_mant_ctrl.sv
// Sequencing controller for the 24-bit restoring mantissa divider.
// Optional divide-by-zero short-cut enabled by defining FDIV_DZ_DETECT_EN.
//
// state  | meaning
// IDLE   | waiting for start, all strobes low
// LOAD   | clear quotient, load dividend into remainder
// ITER   | one quotient bit per cycle, N_ITER cycles
// DONE   | one-cycle done pulse, quotient valid
module fdiv_mant_ctrl #(
    parameter int N_ITER = 24,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             r_ge,
    input  logic             dvsr_zero,
    output logic             busy,
    output logic             done,
    output logic             q_ld,
    output logic             q_sld,
    output logic             q_sin,
    output logic             r_ld,
    output logic             r_shift,
    output logic             r_sub,
    output logic [CNT_W-1:0] iter_cnt,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef FDIV_DZ_DETECT_EN
    logic dz_nxt;
`else
    logic unused_dvsr_zero;
    assign unused_dvsr_zero = dvsr_zero;
    assign dz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
        end else begin
            state    <= state_nxt;
            iter_cnt <= cnt_nxt;
        end
    end

`ifdef FDIV_DZ_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dz <= 1'b0;
        else        dz <= dz_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = iter_cnt;
`ifdef FDIV_DZ_DETECT_EN
        dz_nxt    = dz;
`endif
        busy      = 1'b0;
        done      = 1'b0;
        q_ld      = 1'b0;
        q_sld     = 1'b0;
        q_sin     = 1'b0;
        r_ld      = 1'b0;
        r_shift   = 1'b0;
        r_sub     = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                busy      = 1'b1;
                q_ld      = 1'b1;
                r_ld      = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_ITER;
`ifdef FDIV_DZ_DETECT_EN
                dz_nxt = dvsr_zero;
                if (dvsr_zero) state_nxt = S_DONE;
`endif
            end
            S_ITER: begin
                busy    = 1'b1;
                q_sld   = 1'b1;
                r_shift = 1'b1;
                q_sin   = r_ge;
                r_sub   = r_ge;
                // Counter holds at the last index rather than wrapping.
                if (iter_cnt == CNT_LAST) state_nxt = S_DONE;
                else                      cnt_nxt   = iter_cnt + CNT_W'(1);
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Abort overrides every transition, including start in IDLE.
        if (abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end
    end

endmodule

// File: doc/fdiv_mant_ctrl.md
Name: fdiv_mant_ctrl

Overview:
- Sequencing controller for the 24-bit restoring mantissa divider in the IEEE-754 single-precision divide path.
- Drives the quotient shift register's strobes (load, serial-shift, serial-in) and the remainder register's load/shift/subtract strobes.
- Consumes the datapath comparator flag (remainder >= divisor).
- Offers a start/busy/done handshake to the exponent/sign/normalisation stage that issues divides.

Parameters:
N_ITER, 24, number of quotient bits generated (one per ITER cycle)
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > N_ITER

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a divide; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE with no done pulse
r_ge  input  1  datapath flag: current remainder >= divisor
dvsr_zero  input  1  divisor mantissa is zero (used only with optional feature)
busy  output  1  high in LOAD, ITER, DONE
done  output  1  one-cycle pulse in DONE; quotient register valid
q_ld  output  1  quotient register parallel load (loads 0)
q_sld  output  1  quotient register shift-left enable
q_sin  output  1  quotient register serial input bit
r_ld  output  1  remainder register load dividend
r_shift  output  1  remainder register shift-left enable
r_sub  output  1  subtract divisor before the shift
iter_cnt  output  CNT_W  current iteration index
dz  output  1  divide-by-zero flag (optional feature; else tied 0)

Behaviour:
- Reset (rst_n low, any time, including mid-divide): state=IDLE, iter_cnt=0, dz=0, all outputs 0. The FSM leaves reset on the first clk edge after rst_n rises.
- States: IDLE, LOAD, ITER, DONE (binary encoded).
- IDLE: start=1 -> LOAD. All strobes 0, busy=0.
- LOAD (1 cycle): q_ld=1, r_ld=1, iter_cnt cleared to 0 -> ITER.
- ITER (N_ITER cycles): q_sld=1, r_shift=1, q_sin=r_ge, r_sub=r_ge. iter_cnt increments each cycle; iter_cnt==N_ITER-1 -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE. The quotient register holds the result from this cycle onward until the next LOAD.
- Strobes are combinational decode of the registered state. q_sin and r_sub follow r_ge combinationally, are valid only in ITER, and are forced to 0 elsewhere.
- Latency: start sampled at edge E0 -> LOAD in cycle after E0 -> ITER in the next N_ITER cycles -> done high in cycle E0+N_ITER+2 (26 cycles for the default).
- start while busy: ignored, no queueing.
- abort: has priority over all transitions; in any non-IDLE state -> IDLE next edge, no done, iter_cnt cleared. abort and start together in IDLE: stay IDLE.
- start high in the DONE cycle: ignored; a new start must be presented in IDLE.
- iter_cnt never exceeds N_ITER-1 and never wraps.

Optional Feature:
Macro FDIV_DZ_DETECT_EN.
- Defined: in LOAD, dvsr_zero=1 -> go straight to DONE (skip ITER) with q_ld=1, r_ld=1 still asserted, and dz=1. dz is registered and held until the next LOAD or reset. done pulses one cycle after LOAD.
- Undefined: dvsr_zero is ignored, dz is tied 0, and a zero divisor runs all N_ITER iterations (the datapath yields all-ones quotient bits).

Test Plan:
- Reset mid-ITER (rst_n low at iter_cnt=10) -> all outputs 0 immediately. After release, the FSM idles until start.
- Behavioural datapath, dividend 0xC00000 / divisor 0x800000, start pulse -> done at cycle 26, quotient 0xC00000, q_sld high for exactly 24 cycles.
- Dividend 0x800000 / divisor 0xC00000 -> q_sin sequence 0,1,0,1,... and quotient 0x555555 at done.
- start held high continuously -> back-to-back divides with done every 27 cycles. No strobe activity in the IDLE cycle between divides.
- abort at iter_cnt=5 -> IDLE next cycle, done never pulses, busy low. A new start then runs a full 24 iterations.
- With FDIV_DZ_DETECT_EN, dvsr_zero=1 -> done 2 cycles after start, dz=1, q_sld never asserted. Without the macro: 24 iterations, dz=0.
